// File: rtl/subtype_rr_if.sv
// Request/record bus for subtype_rr_gen: per-channel requests in, FIFO head out.
// master = request source + record consumer, slave = the generator.
interface subtype_rr_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 4
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [N_CH-1:0]        in_valid;
  logic [N_CH-1:0]        in_ready;
  logic [N_CH*CNT_W-1:0]  in_cnt;
  logic [N_CH*DATA_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [CH_W-1:0]        out_ch;
  logic [2:0]             out_mode;
  logic [DATA_W-1:0]      out_subtype;
  logic [LVL_W-1:0]       fifo_level;

  modport master (
    output in_valid, in_cnt, in_data, out_ready,
    input  in_ready, out_valid, out_ch, out_mode, out_subtype, fifo_level
  );

  modport slave (
    input  in_valid, in_cnt, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_mode, out_subtype, fifo_level
  );
endinterface

// File: rtl/subtype_rr_gen.sv
// Round-robin record generator: per-channel (cnt,data) -> {ch, mode, (1<<cnt)+data}
// records, with a per-channel mode FSM and an output FIFO.

// One channel: mode FSM plus the combinational subtype for its current request.
module subtype_rr_lane #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [DATA_W-1:0] data,
  output logic [2:0]        mode,
  output logic [DATA_W-1:0] subtype
);
  typedef enum logic [1:0] {STATE_0, STATE_F0, STATE_244, STATE_DEFAULT} mode_t;
  mode_t state;
  logic [DATA_W-1:0] shift;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= STATE_0;
    else if (acc) begin
      case (state)
        STATE_0:   state <= STATE_F0;
        STATE_F0:  state <= STATE_244;
        STATE_244: state <= STATE_DEFAULT;
        default:   state <= STATE_0;
      endcase
    end
  end

  // Record carries the state before this accept advances it.
  assign mode    = {1'b0, state};
  // Oversized counts contribute nothing rather than aliasing modulo DATA_W.
  assign shift   = (32'(cnt) < DATA_W) ? (DATA_W'(1) << cnt) : '0;
  assign subtype = shift + data;
endmodule

module subtype_rr_gen #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 4
) (
  input logic         clk,
  input logic         rst_n,
  subtype_rr_if.slave bus
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [2:0]        mode;
    logic [DATA_W-1:0] subtype;
  } rec_t;

  logic [CH_W-1:0]              rr_ptr, gidx;
  logic                         found, space, acc, pop;
  logic [N_CH-1:0]              lane_acc;
  logic [N_CH-1:0][2:0]         lane_mode;
  logic [N_CH-1:0][DATA_W-1:0]  lane_sub;
  rec_t                         mem [DEPTH];
  rec_t                         head;
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [LVL_W-1:0]             level;

  // First valid channel at or above rr_ptr, wrapping.
  always_comb begin : arb
    int idx;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && bus.in_valid[idx]) begin
        found = 1'b1;
        gidx  = CH_W'(idx);
      end
    end
  end

  // A full FIFO can still accept when the head leaves on the same edge.
  assign space = (level < LVL_W'(DEPTH)) | bus.out_ready;
  assign acc   = found & space & rst_n;
  assign pop   = (level != '0) & bus.out_ready;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_lane
      assign lane_acc[i] = acc & (gidx == CH_W'(i));
      subtype_rr_lane #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc     (lane_acc[i]),
        .cnt     (bus.in_cnt[i*CNT_W +: CNT_W]),
        .data    (bus.in_data[i*DATA_W +: DATA_W]),
        .mode    (lane_mode[i]),
        .subtype (lane_sub[i])
      );
    end
  endgenerate

  assign bus.in_ready = lane_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr <= '0;
    else if (acc) rr_ptr <= (gidx == CH_W'(N_CH - 1)) ? '0 : gidx + CH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (acc) mem[wr_ptr] <= '{ch: gidx, mode: lane_mode[gidx], subtype: lane_sub[gidx]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({acc, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign head            = mem[rd_ptr];
  assign bus.out_valid   = (level != '0);
  assign bus.out_ch      = bus.out_valid ? head.ch      : '0;
  assign bus.out_mode    = bus.out_valid ? head.mode    : '0;
  assign bus.out_subtype = bus.out_valid ? head.subtype : '0;
  assign bus.fifo_level  = level;
endmodule

// File: tb/tb_subtype_rr_gen.sv
// Bench for subtype_rr_gen: directed scenarios plus randomized traffic against
// a queue-based reference model of arbitration, mode counting and the FIFO.
module tb_subtype_rr_gen;
  localparam int N_CH = 4, DATA_W = 16, CNT_W = 5, DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  subtype_rr_if #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) bus();
  subtype_rr_gen #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int ch; int mode; int sub; } rec_t;
  rec_t q[$];
  int m_ptr;
  int m_acc[N_CH];
  int checks = 0, errors = 0;

  function automatic int exp_sub(int cnt, int data);
    int mask = (1 << DATA_W) - 1;
    return (cnt < DATA_W) ? (((1 << cnt) + data) & mask) : (data & mask);
  endfunction

  // Channel the spec's round-robin rule grants this cycle, or -1.
  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (!(q.size() < DEPTH || bus.out_ready)) return -1;
    for (int k = 0; k < N_CH; k++)
      if (bus.in_valid[(m_ptr + k) % N_CH]) return (m_ptr + k) % N_CH;
    return -1;
  endfunction

  function automatic logic [N_CH-1:0] exp_ready();
    int g = exp_grant();
    return (g < 0) ? '0 : (N_CH'(1) << g);
  endfunction

  task automatic drive(logic [N_CH-1:0] v, bit ordy);
    bus.in_valid = v;
    bus.out_ready = ordy;
  endtask

  task automatic set_req(int c, int cnt, int data);
    bus.in_cnt[c*CNT_W +: CNT_W] = CNT_W'(cnt);
    bus.in_data[c*DATA_W +: DATA_W] = DATA_W'(data);
  endtask

  // Advance one clock and update the model with what should have happened.
  task automatic tick();
    int g;
    bit p;
    rec_t r;
    g = exp_grant();
    p = (q.size() > 0) && bus.out_ready;
    r = '{ch: 0, mode: 0, sub: 0};
    if (g >= 0) begin
      r.ch = g;
      r.mode = m_acc[g] % 4;
      r.sub = exp_sub(int'(bus.in_cnt[g*CNT_W +: CNT_W]), int'(bus.in_data[g*DATA_W +: DATA_W]));
    end
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_ptr = 0;
      foreach (m_acc[i]) m_acc[i] = 0;
    end else begin
      if (p) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back(r);
        m_acc[g]++;
        m_ptr = (g + 1) % N_CH;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive('1, 1'b1);
    for (int c = 0; c < N_CH; c++) set_req(c, c, c);
    tick();
    tick();
    checks++; if (bus.in_ready !== '0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.fifo_level !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", bus.fifo_level); end
    checks++; if ({bus.out_ch, bus.out_mode, bus.out_subtype} !== '0) begin
      errors++; $display("FAIL reset_fields got ch %0d mode %0d sub %h exp 0", bus.out_ch, bus.out_mode, bus.out_subtype); end
    rst_n = 1'b1;
    drive('0, 1'b1);
  endtask

  task automatic test_single();
    do_reset();
    drive(4'b0100, 1'b1);
    set_req(2, 3, 'h0010);
    #1;
    checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", bus.in_ready); end
    tick();
    drive('0, 1'b1);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd2 || bus.out_mode !== 3'd0) begin
      errors++; $display("FAIL single_head got v %b ch %0d mode %0d exp v 1 ch 2 mode 0", bus.out_valid, bus.out_ch, bus.out_mode); end
    checks++; if (bus.out_subtype !== 16'h0018) begin errors++; $display("FAIL single_sub got %h exp 0018", bus.out_subtype); end
    checks++; if (bus.fifo_level !== 3'd1) begin errors++; $display("FAIL single_level1 got %0d exp 1", bus.fifo_level); end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.fifo_level !== 3'd0) begin
      errors++; $display("FAIL single_drain got v %b lvl %0d exp v 0 lvl 0", bus.out_valid, bus.fifo_level); end
  endtask

  task automatic test_rr();
    do_reset();
    drive('1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < N_CH; c++) set_req(c, $urandom_range(0, 31), $urandom_range(0, 65535));
      #1;
      checks++; if (bus.in_ready !== (N_CH'(1) << (k % N_CH))) begin
        errors++; $display("FAIL rr_grant[%0d] got %b exp ch %0d", k, bus.in_ready, k % N_CH); end
      if (k > 0) begin
        checks++; if (bus.out_ch !== 2'((k - 1) % N_CH) || bus.out_mode !== 3'((k - 1) / N_CH)) begin
          errors++; $display("FAIL rr_head[%0d] got ch %0d mode %0d exp ch %0d mode %0d", k - 1, bus.out_ch, bus.out_mode, (k - 1) % N_CH, (k - 1) / N_CH); end
        checks++; if (bus.out_subtype !== DATA_W'(q[0].sub)) begin
          errors++; $display("FAIL rr_sub[%0d] got %h exp %h", k - 1, bus.out_subtype, q[0].sub); end
      end
      tick();
    end
    drive('0, 1'b1);
    tick();
  endtask

  task automatic test_arith();
    int tc[6] = '{15, 15, 20, 0, 31, 16};
    int td[6] = '{'h8000, 'h7FFF, 'h1234, 'hFFFF, 'h0000, 'h0005};
    int te[6] = '{'h0000, 'hFFFF, 'h1234, 'h0000, 'h0000, 'h0005};
    do_reset();
    drive(4'b0001, 1'b1);
    for (int i = 0; i < 6; i++) begin
      set_req(0, tc[i], td[i]);
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_subtype !== DATA_W'(te[i])) begin
        errors++; $display("FAIL arith[%0d] cnt %0d data %h got v %b sub %h exp %h", i, tc[i], td[i], bus.out_valid, bus.out_subtype, te[i]); end
    end
    drive('0, 1'b1);
    tick();
  endtask

  task automatic test_mode_wrap();
    int em[5] = '{0, 1, 2, 3, 0};
    do_reset();
    drive(4'b0010, 1'b1);
    set_req(1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.out_ch !== 2'd1 || bus.out_mode !== 3'(em[i])) begin
        errors++; $display("FAIL mode_wrap[%0d] got ch %0d mode %0d exp ch 1 mode %0d", i, bus.out_ch, bus.out_mode, em[i]); end
    end
    drive('0, 1'b1);
    tick();
  endtask

  task automatic test_full();
    do_reset();
    drive(4'b0001, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      set_req(0, i, i * 'h100);
      #1;
      checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL full_fill[%0d] got %b exp 0001", i, bus.in_ready); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.in_ready !== '0 || bus.fifo_level !== 3'(DEPTH)) begin
        errors++; $display("FAIL full_stall[%0d] got rdy %b lvl %0d exp 0 / %0d", i, bus.in_ready, bus.fifo_level, DEPTH); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_subtype !== 16'h0001 || bus.out_mode !== 3'd0) begin
        errors++; $display("FAIL full_head_stable[%0d] got v %b sub %h mode %0d exp 1 0001 0", i, bus.out_valid, bus.out_subtype, bus.out_mode); end
      tick();
    end
    drive(4'b0001, 1'b1);
    set_req(0, 7, 0);
    #1;
    checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL full_pushpop_ready got %b exp 0001", bus.in_ready); end
    tick();
    checks++; if (bus.fifo_level !== 3'(DEPTH)) begin errors++; $display("FAIL full_pushpop_level got %0d exp %0d", bus.fifo_level, DEPTH); end
    drive('0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      checks++; if (q.size() == 0 || bus.out_valid !== 1'b1 || bus.out_subtype !== DATA_W'(q[0].sub) || bus.out_mode !== 3'(q[0].mode)) begin
        errors++; $display("FAIL full_drain[%0d] got v %b sub %h mode %0d", i, bus.out_valid, bus.out_subtype, bus.out_mode); end
      tick();
    end
    checks++; if (bus.fifo_level !== '0) begin errors++; $display("FAIL full_empty got %0d exp 0", bus.fifo_level); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4'b1000, 1'b0);
    set_req(3, 2, 5);
    tick();
    tick();
    drive(4'b0010, 1'b0);
    set_req(1, 0, 0);
    tick();
    checks++; if (bus.fifo_level !== 3'd3) begin errors++; $display("FAIL mid_fill got %0d exp 3", bus.fifo_level); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.fifo_level !== '0) begin
      errors++; $display("FAIL mid_reset got v %b lvl %0d exp 0 0", bus.out_valid, bus.fifo_level); end
    drive('1, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL mid_rr_restart got %b exp 0001", bus.in_ready); end
    drive(4'b1000, 1'b1);
    set_req(3, 4, 0);
    tick();
    drive('0, 1'b1);
    #1;
    checks++; if (bus.out_ch !== 2'd3 || bus.out_mode !== 3'd0 || bus.out_subtype !== 16'h0010) begin
      errors++; $display("FAIL mid_ch3 got ch %0d mode %0d sub %h exp 3 0 0010", bus.out_ch, bus.out_mode, bus.out_subtype); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 60) != 0);
      drive(N_CH'($urandom), $urandom_range(0, 3) != 0);
      for (int c = 0; c < N_CH; c++) set_req(c, $urandom_range(0, 31), $urandom);
      #1;
      checks++; if (bus.in_ready !== exp_ready()) begin
        errors++; $display("FAIL rand_ready[%0d] got %b exp %b", n, bus.in_ready, exp_ready()); end
      checks++; if (bus.out_valid !== (q.size() > 0) || bus.fifo_level !== 3'(q.size())) begin
        errors++; $display("FAIL rand_level[%0d] got v %b lvl %0d exp lvl %0d", n, bus.out_valid, bus.fifo_level, q.size()); end
      if (q.size() > 0) begin
        checks++; if (bus.out_ch !== 2'(q[0].ch) || bus.out_mode !== 3'(q[0].mode) || bus.out_subtype !== DATA_W'(q[0].sub)) begin
          errors++; $display("FAIL rand_head[%0d] got ch %0d mode %0d sub %h exp %0d %0d %h", n, bus.out_ch, bus.out_mode, bus.out_subtype, q[0].ch, q[0].mode, q[0].sub); end
      end else begin
        checks++; if ({bus.out_ch, bus.out_mode, bus.out_subtype} !== '0) begin
          errors++; $display("FAIL rand_idle[%0d] got ch %0d mode %0d sub %h exp 0", n, bus.out_ch, bus.out_mode, bus.out_subtype); end
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = '0;
    bus.in_cnt = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    m_ptr = 0;
    foreach (m_acc[i]) m_acc[i] = 0;
    test_reset();
    test_single();
    test_rr();
    test_arith();
    test_mode_wrap();
    test_full();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
